// File: rtl/problema1qsys_keys_pio_if.sv
// Avalon-MM slave bus bundle for the keys PIO: word address, select,
// active-low write strobe, write data and registered read data.
interface problema1qsys_keys_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/problema1qsys_keys_pio.sv
// Pushbutton PIO with Avalon-MM slave access, falling-edge capture and a
// masked level interrupt.
// Optional feature: define KEYS_PIO_DEBOUNCE_EN to insert a per-bit
// debounce filter between the synchronizer and the level register.
// Register map: 0 level (RO), 1 reserved (reads 0), 2 irq_mask (RW),
// 3 edge_capture (read, write-1-to-clear).
module problema1qsys_keys_pio #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  problema1qsys_keys_pio_if.slave      bus,
  input  logic [WIDTH-1:0]             in_port,
  output logic                         irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             rd_en;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign rd_en = bus.chipselect &  bus.write_n;

  // Two-flop synchronizer; resets to the released (all-ones) state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef KEYS_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [WIDTH];

  // Per-bit filter: level only follows sync after DEBOUNCE_CYCLES
  // consecutive mismatching cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '1;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  // Without the filter, level is simply the synchronized value one cycle on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level <= '1;
    else          level <= sync2;
  end
`endif

  // Previous-cycle level for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_d <= '1;
    else          level_d <= level;
  end

  assign fall = level_d & ~level;

  // Write-1-to-clear mask for edge_capture, only during an addr-3 write.
  always_comb begin
    clr_mask = '0;
    if (wr_en && bus.address == 2'd3) clr_mask = bus.writedata[WIDTH-1:0];
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          irq_mask <= '0;
    else if (wr_en && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
  end

  // Edge capture: a new edge wins over a same-cycle clear of that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~clr_mask) | fall;
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux[WIDTH-1:0] = level;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  // Registered read data; zero whenever the previous cycle was not a read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   bus.readdata <= '0;
    else if (rd_en) bus.readdata <= rd_mux;
    else            bus.readdata <= '0;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_problema1qsys_keys_pio.sv
// Directed bench for the keys PIO. Stimulus pushes the expected read
// response (data and irq) into a queue; a monitor pops and compares one
// cycle after each observed read.
module tb_problema1qsys_keys_pio;
  localparam int WIDTH = 8;
  localparam int DEB   = 4;
`ifdef KEYS_PIO_DEBOUNCE_EN
  localparam int EDGE_DLY = 1 + DEB;
`else
  localparam int EDGE_DLY = 2;
`endif

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] in_port = '1;
  logic             irq;
  logic             rd_seen = 1'b0;
  int               checks = 0;
  int               errors = 0;
  exp_t             sb[$];

  problema1qsys_keys_pio_if bus ();

  problema1qsys_keys_pio #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_seen <= bus.chipselect & bus.write_n;

  // Monitor: compare the read response, or require zero after idle cycles.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: readdata=%h with no expectation queued", bus.readdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (bus.readdata !== e.data) begin
          errors++;
          $display("FAIL %s data: got %h expected %h", e.name, bus.readdata, e.data);
        end
        checks++;
        if (irq !== e.irq) begin
          errors++;
          $display("FAIL %s irq: got %b expected %b", e.name, irq, e.irq);
        end
      end
    end else if (reset_n) begin
      checks++;
      if (bus.readdata !== 32'h0) begin
        errors++;
        $display("FAIL idle_readdata: got %h expected 00000000", bus.readdata);
      end
    end
  end

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'h0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input string name, input logic [1:0] a,
                    input logic [31:0] d, input logic ei);
    exp_t e;
    @(negedge clk);
    e.name = name; e.data = d; e.irq = ei;
    sb.push_back(e);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    bus.writedata  = 32'h0;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic settle();
    repeat (12 + DEB) @(negedge clk);
  endtask

  task automatic direct_check(input string name, input logic [31:0] got,
                              input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    bus_idle();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    rd("rst_level", 2'd0, 32'hFF, 1'b0);
    rd("rst_rsvd",  2'd1, 32'h00, 1'b0);
    rd("rst_mask",  2'd2, 32'h00, 1'b0);
    rd("rst_cap",   2'd3, 32'h00, 1'b0);

    // Masked falling edge on bit0, then write-1-to-clear.
    wr(2'd2, 32'h01);
    rd("mask_rb", 2'd2, 32'h01, 1'b0);
    in_port = 8'hFE;
    settle();
    rd("b0_cap",   2'd3, 32'h01, 1'b1);
    rd("b0_level", 2'd0, 32'hFE, 1'b1);
    wr(2'd3, 32'h01);
    rd("b0_clr",   2'd3, 32'h00, 1'b0);

    // Unmasked edge on bit5, then enable the mask.
    wr(2'd2, 32'h00);
    in_port = 8'hDE;
    settle();
    rd("b5_nomask", 2'd3, 32'h20, 1'b0);
    wr(2'd2, 32'h20);
    rd("b5_mask",   2'd3, 32'h20, 1'b1);
    wr(2'd3, 32'h20);
    rd("b5_clr",    2'd3, 32'h00, 1'b0);
    wr(2'd0, 32'h00);
    wr(2'd1, 32'hFF);
    rd("level_ro",  2'd0, 32'hDE, 1'b0);
    rd("rsvd_ro",   2'd1, 32'h00, 1'b0);

    // Edge on bit2 detected in the same cycle as its clear: set wins.
    @(negedge clk);
    in_port = 8'hDA;
    repeat (EDGE_DLY) @(negedge clk);
    wr(2'd3, 32'h04);
    rd("set_wins", 2'd3, 32'h04, 1'b0);
    wr(2'd3, 32'h04);
    rd("set_clr",  2'd3, 32'h00, 1'b0);

    // Rising edges are not captured.
    in_port = 8'hFF;
    settle();
    rd("rise_nocap", 2'd3, 32'h00, 1'b0);
    rd("rise_level", 2'd0, 32'hFF, 1'b0);

`ifdef KEYS_PIO_DEBOUNCE_EN
    // Three-cycle glitches on bit3 must be filtered out.
    wr(2'd2, 32'h08);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk); in_port = 8'hF7;
      repeat (3) @(negedge clk);
      in_port = 8'hFF;
      repeat (3) @(negedge clk);
    end
    settle();
    rd("glitch_cap",   2'd3, 32'h00, 1'b0);
    rd("glitch_level", 2'd0, 32'hFF, 1'b0);
    in_port = 8'hF7;
    settle();
    rd("held_cap", 2'd3, 32'h08, 1'b1);
    in_port = 8'hFF;
    settle();
    wr(2'd3, 32'h08);
`endif

    // Fill edge_capture, then reset mid-flight.
    wr(2'd2, 32'hFF);
    in_port = 8'h00;
    settle();
    rd("all_cap", 2'd3, 32'hFF, 1'b1);
    @(negedge clk);
    in_port = 8'hFF;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    direct_check("rst_irq",      {31'h0, irq},  32'h0);
    direct_check("rst_readdata", bus.readdata, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    settle();
    rd("post_level", 2'd0, 32'hFF, 1'b0);
    rd("post_mask",  2'd2, 32'h00, 1'b0);
    rd("post_cap",   2'd3, 32'h00, 1'b0);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
